// File: rtl/jk_cnt_pkg.sv
// rtl/jk_cnt_pkg.sv - shared JK excitation codes and default width for the modulo counter
package jk_cnt_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Codes are {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with asynchronous active-high reset
module jk_cell
    import jk_cnt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - up/down modulo counter built from JK cells driven by computed excitation
module jk_mod_counter
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cell_q;
    logic [WIDTH-1:0] n_d;
    logic             wrap_d;
    logic             wrap_q;

    always_comb begin
        n_d    = cell_q;
        wrap_d = 1'b0;
        if (load) begin
            n_d = (load_val > mod_max) ? mod_max : load_val;
        end else if (en) begin
            if (up) begin
                if (cell_q >= mod_max) begin
                    n_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    n_d = cell_q + ONE;
                end
            end else begin
                // No clamp here: a count above a lowered mod_max walks down normally
                if (cell_q == '0) begin
                    n_d    = mod_max;
                    wrap_d = 1'b1;
                end else begin
                    n_d = cell_q - ONE;
                end
            end
        end
    end

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        if (reset) begin
            j_vec = '0;
            k_vec = '0;
        end else if (load) begin
            j_vec = n_d;
            k_vec = ~n_d;
        end else begin
            j_vec = n_d ^ cell_q;
            k_vec = n_d ^ cell_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (cell_q[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign q    = cell_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - directed self-checking bench for jk_mod_counter
module tb_jk_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] mod_max;
    logic [3:0] q;
    logic [3:0] j_vec;
    logic [3:0] k_vec;
    logic       wrap;

    int checks;
    int failures;

    jk_mod_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .mod_max  (mod_max),
        .q        (q),
        .j_vec    (j_vec),
        .k_vec    (k_vec),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;
        mod_max  = 4'd9;

        #1 reset = 1'b1;
        #2;
        check("reset_q", q, 4'd0);
        check("reset_wrap", wrap, 1'b0);
        check("reset_j", j_vec, 4'd0);
        check("reset_k", k_vec, 4'd0);
        step();
        reset = 1'b0;
        en    = 1'b1;

        // Up-wrap: mod_max=9, twelve clocks from zero
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("upwrap_q_%0d", i), q, (i + 1) % 10);
            check($sformatf("upwrap_wrap_%0d", i), wrap, (i == 9) ? 1 : 0);
        end

        // Down-wrap from zero with mod_max=5
        mod_max  = 4'd5;
        load_val = 4'd0;
        load     = 1'b1;
        step();
        check("load0_q", q, 4'd0);
        load = 1'b0;
        up   = 1'b0;
        #1;
        check("downwrap_j", j_vec, 4'b0101);
        check("downwrap_k", k_vec, 4'b0101);
        step();
        check("downwrap_q", q, 4'd5);
        check("downwrap_wrap", wrap, 1'b1);
        step();
        check("down_q", q, 4'd4);
        check("down_wrap", wrap, 1'b0);

        // Load clamp with en also high
        mod_max  = 4'd6;
        load_val = 4'd13;
        load     = 1'b1;
        en       = 1'b1;
        #1;
        check("clamp_j", j_vec, 4'b0110);
        check("clamp_k", k_vec, 4'b1001);
        step();
        check("clamp_q", q, 4'd6);
        check("clamp_wrap", wrap, 1'b0);

        // Hold at 3
        load_val = 4'd3;
        step();
        check("load3_q", q, 4'd3);
        load = 1'b0;
        en   = 1'b0;
        #1;
        check("hold_j", j_vec, 4'd0);
        check("hold_k", k_vec, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold_q_%0d", i), q, 4'd3);
            check($sformatf("hold_wrap_%0d", i), wrap, 1'b0);
        end

        // Async reset between edges with q=7
        mod_max  = 4'd9;
        load_val = 4'd7;
        load     = 1'b1;
        step();
        check("load7_q", q, 4'd7);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("areset_q", q, 4'd0);
        check("areset_wrap", wrap, 1'b0);
        check("areset_j", j_vec, 4'd0);
        #1 reset = 1'b0;
        step();
        check("resume_q1", q, 4'd1);
        step();
        check("resume_q2", q, 4'd2);

        // mod_max lowered below the count: down decrements, up wraps
        load_val = 4'd8;
        load     = 1'b1;
        step();
        check("load8_q", q, 4'd8);
        load    = 1'b0;
        mod_max = 4'd3;
        up      = 1'b0;
        step();
        check("lowered_down_q", q, 4'd7);
        check("lowered_down_wrap", wrap, 1'b0);
        up = 1'b1;
        step();
        check("lowered_up_q", q, 4'd0);
        check("lowered_up_wrap", wrap, 1'b1);

        // Degenerate mod_max=0
        mod_max = 4'd0;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0) ? 1'b0 : 1'b1;
            #1;
            check($sformatf("degen_j_%0d", i), j_vec, 4'd0);
            step();
            check($sformatf("degen_q_%0d", i), q, 4'd0);
            check($sformatf("degen_wrap_%0d", i), wrap, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter bit width (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port en, input, 1, count enable.
REQ-005 SHALL have port up, input, 1, direction select: 1 counts up, 0 counts down.
REQ-006 SHALL have port load, input, 1, synchronous parallel load request.
REQ-007 SHALL have port load_val, input, WIDTH, value to load.
REQ-008 SHALL have port mod_max, input, WIDTH, terminal count; the count range is 0..mod_max.
REQ-009 SHALL have port q, output, WIDTH, current count (flip-flop outputs).
REQ-010 SHALL have port j_vec, output, WIDTH, J excitation currently driven into each bit cell.
REQ-011 SHALL have port k_vec, output, WIDTH, K excitation currently driven into each bit cell.
REQ-012 SHALL have port wrap, output, 1, registered pulse, high for one cycle after a wrap transition.

Function
REQ-013 SHALL hold the count in WIDTH JK bit cells; the only next-state path is the J/K excitation.
REQ-014 SHALL compute the target next count n with this priority: load, then en, then hold.
REQ-015 SHALL compute n = min(load_val, mod_max) when load=1.
REQ-016 SHALL compute n as follows when load=0, en=1, up=1: 0 if q >= mod_max (wrap), else q+1.
REQ-017 SHALL compute n as follows when load=0, en=1, up=0: mod_max if q == 0 (wrap), else q-1.
REQ-018 SHALL compute n = q when load=0 and en=0.
REQ-019 SHALL drive excitation on load as set/reset per bit: J_i = n_i, K_i = ~n_i (codes 10/01).
REQ-020 SHALL drive excitation otherwise as toggle/hold per bit: J_i = K_i = 1 if n_i != q_i, else 00.
REQ-021 SHALL keep j_vec/k_vec combinational with zero latency; q takes the value n one clock later.
REQ-022 SHALL set wrap=1 on the edge following a cycle in which REQ-016/017 selected the wrap branch, and 0 otherwise.
REQ-023 SHALL, when mod_max = 0, hold q at 0 and assert wrap after every enabled cycle.
REQ-024 SHALL, when load and en are high together, perform the load only and assert no wrap.
REQ-025 SHALL, when counting down with q > mod_max (mod_max lowered mid-run), decrement normally without clamping.
REQ-026 SHALL use unsigned arithmetic of WIDTH bits throughout, with no carry beyond WIDTH.

Reset
REQ-027 SHALL, while reset=1, force q = 0 and wrap = 0 immediately, independent of clk.
REQ-028 SHALL drive j_vec = k_vec = 0 while reset=1.
REQ-029 SHALL, when reset deasserts, evaluate normally from the first rising clk edge where reset=0; reset asserted mid-count discards the count with no partial update.

Structure
REQ-030 SHALL take the JK code constants (HOLD=00, RST=01, SET=10, TGL=11) and the default WIDTH from shared package jk_cnt_pkg.
REQ-031 SHALL instantiate sub-module jk_cell WIDTH times: one JK flip-flop with async active-high reset, ports clk, reset, j, k, q.
REQ-032 SHALL implement excitation and next-count logic in jk_mod_counter only, with no state besides the jk_cell array and the wrap register.

Verification
REQ-033 SHALL cover this up-wrap case: mod_max=9, up=1, en=1 from reset, 12 clocks -> q sequence 1..9,0,1,2; wrap high exactly the cycle after q returns to 0.
REQ-034 SHALL cover this down-wrap case: mod_max=5, q=0, up=0, en=1 -> q=5 next cycle, wrap=1; j_vec=k_vec=4'b0101 in the preceding cycle.
REQ-035 SHALL cover this load-clamp case: mod_max=6, load=1, en=1, load_val=13 -> q=6, wrap=0; j_vec=0110, k_vec=1001 during the load cycle.
REQ-036 SHALL cover this hold case: en=0, q=3 for 5 clocks -> q stays 3, j_vec=k_vec=0, wrap=0.
REQ-037 SHALL cover this async-reset case: reset pulsed between clk edges with q=7 -> q=0 and wrap=0 before the next edge; counting resumes from 1 after release.
REQ-038 SHALL cover this degenerate case: mod_max=0, en=1, up toggled -> q stays 0 and wrap=1 every cycle.
